// File: rtl/number_signal_pkg.sv
// Shared constants for the signed-number classifier: default operand width and
// the most negative two's-complement value at that width.
package number_signal_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [DEFAULT_WIDTH-1:0] MIN_NEG = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

    // Most negative pattern for any width: MSB set, all other bits clear.
    function automatic logic [31:0] min_neg_pattern(input int unsigned width);
        logic [31:0] pat;
        pat = '0;
        pat[width-1] = 1'b1;
        return pat;
    endfunction

endpackage

// File: rtl/sign_abs_core.sv
// Combinational classifier: sign, zero, strictly-positive, absolute value and
// the overflow flag for the single operand whose magnitude needs the MSB.
module sign_abs_core
    import number_signal_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] number,
    output logic             neg,
    output logic             zero,
    output logic             pos,
    output logic [WIDTH-1:0] magnitude,
    output logic             mag_overflow
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        neg          = number[WIDTH-1];
        zero         = (number == '0);
        pos          = !number[WIDTH-1] && (number != '0);
        // Negating the most negative value wraps back to itself, which is the
        // correct unsigned magnitude 2^(WIDTH-1).
        magnitude    = number[WIDTH-1] ? (~number + ONE) : number;
        mag_overflow = (number == NEG_MIN);
    end

endmodule

// File: rtl/number_signal.sv
// Registered signed-number classifier: one-cycle latency, accepts an operand
// every cycle, result outputs hold between accepted operands.
module number_signal
    import number_signal_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] number,
    output logic             out_valid,
    output logic             num_signal,
    output logic             is_zero,
    output logic             is_positive,
    output logic [WIDTH-1:0] magnitude,
    output logic             mag_overflow
);

    logic             core_neg;
    logic             core_zero;
    logic             core_pos;
    logic [WIDTH-1:0] core_mag;
    logic             core_ovf;

    logic             valid_d, valid_q;
    logic             sign_d, sign_q;
    logic             zero_d, zero_q;
    logic             pos_d, pos_q;
    logic [WIDTH-1:0] mag_d, mag_q;
    logic             ovf_d, ovf_q;

    sign_abs_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .number      (number),
        .neg         (core_neg),
        .zero        (core_zero),
        .pos         (core_pos),
        .magnitude   (core_mag),
        .mag_overflow(core_ovf)
    );

    always_comb begin
        valid_d = in_valid;
        sign_d  = sign_q;
        zero_d  = zero_q;
        pos_d   = pos_q;
        mag_d   = mag_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            sign_d = core_neg;
            zero_d = core_zero;
            pos_d  = core_pos;
            mag_d  = core_mag;
            ovf_d  = core_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            pos_q   <= 1'b0;
            mag_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            pos_q   <= pos_d;
            mag_q   <= mag_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid    = valid_q;
    assign num_signal   = sign_q;
    assign is_zero      = zero_q;
    assign is_positive  = pos_q;
    assign magnitude    = mag_q;
    assign mag_overflow = ovf_q;

endmodule

// File: tb/tb_number_signal.sv
// Directed bench for number_signal at WIDTH=8 with hand-computed expectations.
module tb_number_signal;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] number;
    logic         out_valid;
    logic         num_signal;
    logic         is_zero;
    logic         is_positive;
    logic [W-1:0] magnitude;
    logic         mag_overflow;

    int total = 0;
    int bad   = 0;

    number_signal #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .number      (number),
        .out_valid   (out_valid),
        .num_signal  (num_signal),
        .is_zero     (is_zero),
        .is_positive (is_positive),
        .magnitude   (magnitude),
        .mag_overflow(mag_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic v, input logic s, input logic z,
                              input logic p, input logic [W-1:0] m, input logic o);
        check({tag, ".out_valid"},    32'(out_valid),    32'(v));
        check({tag, ".num_signal"},   32'(num_signal),   32'(s));
        check({tag, ".is_zero"},      32'(is_zero),      32'(z));
        check({tag, ".is_positive"},  32'(is_positive),  32'(p));
        check({tag, ".magnitude"},    32'(magnitude),    32'(m));
        check({tag, ".mag_overflow"}, 32'(mag_overflow), 32'(o));
    endtask

    // Drive on the falling edge, let the rising edge capture, sample 1 time unit later.
    task automatic drive(input logic v, input logic [W-1:0] n);
        @(negedge clk);
        in_valid = v;
        number   = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        number   = '0;
        #2;
        expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming run, valid every cycle
        drive(1'b1, 8'b00000111);
        expect_all("pos7", 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0);
        drive(1'b1, 8'b11110110);
        expect_all("neg10", 1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 1'b0);
        drive(1'b1, 8'b01110110);
        expect_all("pos118", 1'b1, 1'b0, 1'b0, 1'b1, 8'd118, 1'b0);
        drive(1'b1, 8'b11111111);
        expect_all("neg1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
        drive(1'b1, 8'b00000000);
        expect_all("zero", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 8'b10000000);
        expect_all("min_neg", 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1);
        drive(1'b1, 8'b01111111);
        expect_all("max_pos", 1'b1, 1'b0, 1'b0, 1'b1, 8'd127, 1'b0);

        // Idle cycles with a changing operand: results must hold
        drive(1'b0, 8'b10000001);
        expect_all("hold1", 1'b0, 1'b0, 1'b0, 1'b1, 8'd127, 1'b0);
        drive(1'b0, 8'b00000000);
        expect_all("hold2", 1'b0, 1'b0, 1'b0, 1'b1, 8'd127, 1'b0);

        drive(1'b1, 8'b10000001);
        expect_all("neg127", 1'b1, 1'b1, 1'b0, 1'b0, 8'd127, 1'b0);

        // Reset between clock edges while a result is presented
        drive(1'b1, 8'b00000101);
        expect_all("pos5", 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        expect_all("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        expect_all("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 8'b11110110);
        expect_all("post_rst_neg10", 1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 1'b0);
        drive(1'b0, 8'b00000000);
        expect_all("post_rst_drop", 1'b0, 1'b1, 1'b0, 1'b0, 8'd10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
